// File: rtl/dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_scheduler
// Description : One-entry dispatch buffer between decode/rename/ROB and the
//               per-function-unit issue queues. Accepts one renamed uop per
//               cycle, steers it to a single issue queue by one-hot futype,
//               and serializes CSR/MISC uops against the ROB.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               flush               - pipeline flush, empties the buffer
//               in_valid/in_ready   - handshake with decode (dispatch_ready)
//               in_futype           - one-hot FU class (lowest set bit wins)
//               in_payload          - packed uop fields
//               rob_empty           - ROB holds no uncommitted entries
//               iq_valid/iq_ready   - one-hot request / per-queue free slot
//               iq_payload          - shared payload bus to all issue queues
//               serial_busy         - serial uop waiting or in flight
//               stall_cnt           - saturating count of stalled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_scheduler #(
    parameter int                NUM_FU      = 7,
    parameter int                PAYLOAD_W   = 128,
    parameter logic [NUM_FU-1:0] SERIAL_MASK = 7'b0110000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_FU-1:0]    in_futype,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 rob_empty,
    output logic [NUM_FU-1:0]    iq_valid,
    input  logic [NUM_FU-1:0]    iq_ready,
    output logic [PAYLOAD_W-1:0] iq_payload,
    output logic                 serial_busy,
    output logic [31:0]          stall_cnt
);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_HOLD      = 2'd1;
    localparam logic [1:0] c_ST_SER_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_SER_BLOCK = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [NUM_FU-1:0]    r_sel;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [31:0]          r_stall_cnt;

    logic [NUM_FU-1:0]    w_sel_in;
    logic                 w_serial_in;
    logic                 w_accept;
    logic                 w_send;
    logic                 w_load;
    logic [NUM_FU-1:0]    w_iq_valid;
    logic                 w_in_ready;

    // Isolate the lowest set bit; multi-hot futypes collapse to one queue and
    // the serialization test only looks at the surviving bit.
    assign w_sel_in    = in_futype & (-in_futype);
    assign w_serial_in = |(w_sel_in & SERIAL_MASK);

    // Request is a function of state and buffered select only; the serial
    // request is additionally gated by rob_empty.
    always_comb begin
        w_iq_valid = '0;
        if (r_state == c_ST_HOLD) begin
            w_iq_valid = r_sel;
        end else if (r_state == c_ST_SER_WAIT && rob_empty) begin
            w_iq_valid = r_sel;
        end
    end

    assign w_send = |(w_iq_valid & iq_ready);

    // In HOLD the slot frees up in the same cycle it drains, giving one
    // uop per cycle back-to-back.
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            c_ST_IDLE: w_in_ready = 1'b1;
            c_ST_HOLD: w_in_ready = w_send;
            default:   w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Zero futype is accepted and dropped: no load, stay IDLE.
                if (w_accept && (w_sel_in != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_serial_in ? c_ST_SER_WAIT : c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (w_send) begin
                    w_state_nxt = c_ST_IDLE;
                    if (w_accept && (w_sel_in != '0)) begin
                        w_load      = 1'b1;
                        w_state_nxt = w_serial_in ? c_ST_SER_WAIT : c_ST_HOLD;
                    end
                end
            end
            c_ST_SER_WAIT: begin
                if (w_send) begin
                    w_state_nxt = c_ST_SER_BLOCK;
                end
            end
            c_ST_SER_BLOCK: begin
                // The serial uop is already in the ROB, so an empty ROB here
                // means it has committed.
                if (rob_empty) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = c_ST_IDLE;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_sel       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_sel <= w_sel_in;
            end
            if (in_valid && !w_in_ready && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    // Payload content is meaningless while no request is raised, so it is
    // left out of reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_payload <= in_payload;
        end
    end

    assign in_ready    = w_in_ready;
    assign iq_valid    = w_iq_valid;
    assign iq_payload  = r_payload;
    assign serial_busy = (r_state == c_ST_SER_WAIT) || (r_state == c_ST_SER_BLOCK);
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire
